compare_unit: RTL

COMPARE_UNIT -- requirements
Module: compare_unit

---
 rtl/compare_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/compare_unit.sv
// Multi-cycle magnitude comparator: scans operands MSB-chunk first and exits early
// on the first differing chunk, reporting LT/LE/GT/GE under signed or unsigned mode.
module compare_unit #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] register_A,
   input  logic [WIDTH-1:0] register_B,
   output logic             busy,
   output logic             done,
   output logic             sign_flag,
   output logic             zero_flag,
   output logic             result
);

   localparam int unsigned NChunk  = WIDTH / CHUNK;
   localparam int unsigned IdxW    = (NChunk > 1) ? $clog2(NChunk) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e           state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             sign_q, sign_d, zero_q, zero_d, res_q, res_d;

   logic [WIDTH-1:0] a_eff, b_eff, a_sh, b_sh;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   int unsigned      shamt;
   logic             chunk_lt, chunk_eq, decide, accept;
   logic             dec_sign, dec_zero, dec_res;

   // Chunk selection; flipping both MSBs maps two's complement onto unsigned order.
   always_comb begin
      a_eff = a_q;
      b_eff = b_q;
      if (op_q[0] && idx_q == '0) begin
         a_eff[WIDTH-1] = ~a_q[WIDTH-1];
         b_eff[WIDTH-1] = ~b_q[WIDTH-1];
      end
      shamt    = (NChunk - 1 - 32'(idx_q)) * CHUNK;
      a_sh     = a_eff >> shamt;
      b_sh     = b_eff >> shamt;
      a_chunk  = a_sh[CHUNK-1:0];
      b_chunk  = b_sh[CHUNK-1:0];
      chunk_lt = a_chunk < b_chunk;
      chunk_eq = a_chunk == b_chunk;
      decide   = !chunk_eq || (idx_q == LastIdx);
      dec_sign = chunk_lt;
      dec_zero = chunk_eq;
      case (op_q[2:1])
         2'b00:   dec_res = dec_sign;
         2'b01:   dec_res = dec_sign | dec_zero;
         2'b10:   dec_res = ~(dec_sign | dec_zero);
         default: dec_res = ~dec_sign;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StScan;
         StScan:  if (decide) state_d = StDone;
         StDone:  state_d = start ? StScan : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy      = (state_q == StScan);
      done      = (state_q == StDone);
      sign_flag = sign_q;
      zero_flag = zero_q;
      result    = res_q;
   end

   // Datapath next-state
   always_comb begin
      accept = start && (state_q != StScan);
      a_d    = a_q;
      b_d    = b_q;
      op_d   = op_q;
      idx_d  = idx_q;
      sign_d = sign_q;
      zero_d = zero_q;
      res_d  = res_q;
      if (accept) begin
         a_d   = register_A;
         b_d   = register_B;
         op_d  = op;
         idx_d = '0;
      end else if (state_q == StScan) begin
         if (decide) begin
            sign_d = dec_sign;
            zero_d = dec_zero;
            res_d  = dec_res;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         idx_q  <= '0;
         sign_q <= 1'b0;
         zero_q <= 1'b0;
         res_q  <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         op_q   <= op_d;
         idx_q  <= idx_d;
         sign_q <= sign_d;
         zero_q <= zero_d;
         res_q  <= res_d;
      end
   end

endmodule
